wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter for the execute stage. Owns the single register-file write port and shares it between two result producers: the integer unit (ALU results) and the data-memory load-return path. Each producer has a one-entry holding register with valid/ready handshake. A fixed-priority arbiter with a starvation guard selects the winner, and the result drives a registered write-back port into the decode/register-file stage.

## Interface
- XLEN, 32, data width of results and write-back data
- STARVE_MAX, 4, consecutive lost arbitrations after which a waiting ALU result takes priority; range 1..15

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- i_flush  in  1  discard the pending ALU result (speculative squash)
- i_alu_valid  in  1  ALU result offered
- o_alu_ready  out  1  ALU result accepted when valid&&ready
- i_alu_waddr  in  5  ALU destination register
- i_alu_wdata  in  XLEN  ALU result
- i_ld_valid  in  1  load data offered
- o_ld_ready  out  1  load data accepted when valid&&ready
- i_ld_waddr  in  5  load destination register
- i_ld_wdata  in  XLEN  load data
- o_wb_rd_wvalid  out  1  register-file write strobe, one cycle per write
- o_wb_rd_waddr  out  5  write address
- o_wb_rd_wdata  out  XLEN  write data
- o_busy  out  1  either holding register occupied

## Operation
- Holding registers: alu_hold and ld_hold, each {valid, waddr, wdata}. A handshake (valid&&ready) loads the hold on the next edge.
- x0 filter: an accepted transfer with waddr==0 is consumed. The hold is not loaded and the transfer never reaches the write port.
- Grant is computed combinationally from hold valids, starve_cnt and i_flush only. It never depends on i_*_valid in the same cycle.
  - Only one hold valid: that hold is granted.
  - Both valid and starve_cnt < STARVE_MAX: the load is granted.
  - Both valid and starve_cnt == STARVE_MAX: the ALU is granted.
  - i_flush high: the ALU hold is not eligible for grant that cycle.
- Ready signals:
  - o_alu_ready = !alu_hold.valid || alu_granted.
  - o_ld_ready = !ld_hold.valid || ld_granted.
  - There is no combinational path from any i_*_valid to any o_*_ready.
- Granted hold: it is cleared on the edge unless it is refilled by a simultaneous handshake. The output register loads {1, waddr, wdata}.
- No grant: o_wb_rd_wvalid is 0 next cycle. waddr and wdata hold their last values.
- starve_cnt (4 bits):
  - Increments when alu_hold is valid and the load is granted.
  - Clears when the ALU is granted, when alu_hold is empty, or on flush.
  - Saturates at STARVE_MAX.
- Flush:
  - Clears alu_hold.valid and starve_cnt on the edge.
  - Blocks an ALU handshake in the same cycle: o_alu_ready is forced 0 while i_flush is high.
  - ld_hold and the output register are unaffected.
- Both holds targeting the same rd: they are written in grant order as two separate strobes. There is no merging.
- o_busy = alu_hold.valid || ld_hold.valid (registered state only).

## Timing
- Reset values (rst high at an edge): both holds invalid, starve_cnt=0, o_wb_rd_wvalid=0, o_wb_rd_waddr=0, o_wb_rd_wdata=0, o_busy=0. o_alu_ready and o_ld_ready are 1 after reset, and 0 while rst is high.
- Reset mid-operation discards both holds and any in-flight output strobe. No write is issued in the cycle after reset deassertion.
- Uncontended latency:
  - Handshake at edge t loads the hold.
  - Grant occurs in cycle t..t+1.
  - o_wb_rd_wvalid is high in the cycle after edge t+1, i.e. 2 cycles from handshake to write strobe.
- Uncontended throughput: 1 result per cycle per source, because ready stays high while the hold drains.
- Contended throughput: 1 write per cycle total. The losing source's ready is 0 until its hold is granted.
- Worst-case ALU wait with continuous loads: STARVE_MAX+1 grant cycles.

## Test plan
- Reset: drive rst for 2 cycles with valids high → no handshake, all outputs 0. First release cycle shows o_alu_ready=o_ld_ready=1 and o_wb_rd_wvalid=0.
- Single ALU write: alu waddr=5, wdata=0xDEADBEEF, valid for 1 cycle → exactly one strobe 2 cycles later with waddr=5, data=0xDEADBEEF.
- Simultaneous: ALU (rd=3, 0x11) and load (rd=3, 0x22) in the same cycle → load strobe (rd3=0x22), then ALU strobe (rd3=0x11) on consecutive cycles. o_alu_ready=0 for one cycle.
- Starvation: loads valid every cycle (rd=1..), one ALU rd=7, STARVE_MAX=4 → exactly 4 load strobes, then the rd=7 strobe, then loads resume.
- Flush: ALU rd=9 held behind a load, i_flush pulsed → no rd=9 strobe ever; load still written; starve_cnt=0.
- x0: load waddr=0, data=0xFFFF_FFFF → accepted (ready=1), no strobe, o_busy stays 0.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Write-back port arbiter between the ALU and load-return paths,
//             with one-entry holds and a starvation guard favouring the ALU.
//  Revision : 1.0  initial release
// ============================================================================
module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_alu_valid,
  output logic            o_alu_ready,
  input  logic [4:0]      i_alu_waddr,
  input  logic [XLEN-1:0] i_alu_wdata,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [4:0]      i_ld_waddr,
  input  logic [XLEN-1:0] i_ld_wdata,
  output logic            o_wb_rd_wvalid,
  output logic [4:0]      o_wb_rd_waddr,
  output logic [XLEN-1:0] o_wb_rd_wdata,
  output logic            o_busy
);

  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

  logic            alu_v_q, ld_v_q;
  logic [4:0]      alu_addr_q, ld_addr_q;
  logic [XLEN-1:0] alu_data_q, ld_data_q;
  logic [3:0]      starve_q;
  logic            wb_valid_q;
  logic [4:0]      wb_addr_q;
  logic [XLEN-1:0] wb_data_q;

  logic w_alu_gnt, w_ld_gnt, w_alu_load, w_ld_load;

  // Grant looks only at registered holds, the guard counter and flush.
  assign w_alu_gnt = alu_v_q && !i_flush && (!ld_v_q || (starve_q == C_STARVE_MAX));
  assign w_ld_gnt  = ld_v_q && !w_alu_gnt;

  assign o_alu_ready = !rst && !i_flush && (!alu_v_q || w_alu_gnt);
  assign o_ld_ready  = !rst && (!ld_v_q || w_ld_gnt);

  // Writes to x0 are accepted but dropped before reaching a hold.
  assign w_alu_load = i_alu_valid && o_alu_ready && (i_alu_waddr != 5'd0);
  assign w_ld_load  = i_ld_valid  && o_ld_ready  && (i_ld_waddr  != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_v_q    <= 1'b0;
      alu_addr_q <= '0;
      alu_data_q <= '0;
      ld_v_q     <= 1'b0;
      ld_addr_q  <= '0;
      ld_data_q  <= '0;
      starve_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      if (w_alu_load) begin
        alu_v_q    <= 1'b1;
        alu_addr_q <= i_alu_waddr;
        alu_data_q <= i_alu_wdata;
      end else if (w_alu_gnt || i_flush) begin
        alu_v_q <= 1'b0;
      end

      if (w_ld_load) begin
        ld_v_q    <= 1'b1;
        ld_addr_q <= i_ld_waddr;
        ld_data_q <= i_ld_wdata;
      end else if (w_ld_gnt) begin
        ld_v_q <= 1'b0;
      end

      if (i_flush || !alu_v_q || w_alu_gnt) begin
        starve_q <= '0;
      end else if (w_ld_gnt && (starve_q != C_STARVE_MAX)) begin
        starve_q <= starve_q + 4'd1;
      end

      wb_valid_q <= w_alu_gnt || w_ld_gnt;
      if (w_alu_gnt) begin
        wb_addr_q <= alu_addr_q;
        wb_data_q <= alu_data_q;
      end else if (w_ld_gnt) begin
        wb_addr_q <= ld_addr_q;
        wb_data_q <= ld_data_q;
      end
    end
  end

  assign o_wb_rd_wvalid = wb_valid_q;
  assign o_wb_rd_waddr  = wb_addr_q;
  assign o_wb_rd_wdata  = wb_data_q;
  assign o_busy         = alu_v_q || ld_v_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter
//  Purpose  : Directed self-checking bench for wb_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush;
  logic        i_alu_valid, i_ld_valid;
  logic        o_alu_ready, o_ld_ready;
  logic [4:0]  i_alu_waddr, i_ld_waddr;
  logic [31:0] i_alu_wdata, i_ld_wdata;
  logic        o_wb_rd_wvalid;
  logic [4:0]  o_wb_rd_waddr;
  logic [31:0] o_wb_rd_wdata;
  logic        o_busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [36:0] wlog[$];
  logic [36:0] exp_seq[8];
  logic        a_acc, l_acc, alu_pend;
  int          ld_rd, n9;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_flush        (i_flush),
    .i_alu_valid    (i_alu_valid),
    .o_alu_ready    (o_alu_ready),
    .i_alu_waddr    (i_alu_waddr),
    .i_alu_wdata    (i_alu_wdata),
    .i_ld_valid     (i_ld_valid),
    .o_ld_ready     (o_ld_ready),
    .i_ld_waddr     (i_ld_waddr),
    .i_ld_wdata     (i_ld_wdata),
    .o_wb_rd_wvalid (o_wb_rd_wvalid),
    .o_wb_rd_waddr  (o_wb_rd_waddr),
    .o_wb_rd_wdata  (o_wb_rd_wdata),
    .o_busy         (o_busy)
  );

  // Record every write strobe as {waddr, wdata}.
  always @(negedge clk) begin
    if (o_wb_rd_wvalid) wlog.push_back({o_wb_rd_waddr, o_wb_rd_wdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_flush     = 1'b0;
    i_alu_valid = 1'b0;
    i_ld_valid  = 1'b0;
    i_alu_waddr = 5'd0;
    i_alu_wdata = 32'd0;
    i_ld_waddr  = 5'd0;
    i_ld_wdata  = 32'd0;
  endtask

  initial begin
    // Reset with both producers offering data
    idle_inputs();
    rst = 1'b1;
    i_alu_valid = 1'b1; i_alu_waddr = 5'd4; i_alu_wdata = 32'h1234;
    i_ld_valid  = 1'b1; i_ld_waddr  = 5'd8; i_ld_wdata  = 32'h5678;
    cyc();
    check("rst_alu_ready", o_alu_ready, 0);
    check("rst_ld_ready", o_ld_ready, 0);
    cyc();
    check("rst_wvalid", o_wb_rd_wvalid, 0);
    check("rst_waddr", o_wb_rd_waddr, 0);
    check("rst_wdata", o_wb_rd_wdata, 0);
    check("rst_busy", o_busy, 0);
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rel_alu_ready", o_alu_ready, 1);
    check("rel_ld_ready", o_ld_ready, 1);
    check("rel_wvalid", o_wb_rd_wvalid, 0);
    cyc();
    check("rel_wvalid2", o_wb_rd_wvalid, 0);
    check("rel_busy", o_busy, 0);
    check("rel_nolog", wlog.size(), 0);

    // Single ALU write
    wlog.delete();
    i_alu_valid = 1'b1; i_alu_waddr = 5'd5; i_alu_wdata = 32'hDEADBEEF;
    cyc();
    i_alu_valid = 1'b0;
    check("single_busy", o_busy, 1);
    check("single_early", o_wb_rd_wvalid, 0);
    cyc();
    check("single_wvalid", o_wb_rd_wvalid, 1);
    check("single_waddr", o_wb_rd_waddr, 5);
    check("single_wdata", o_wb_rd_wdata, 32'hDEADBEEF);
    check("single_busy_clr", o_busy, 0);
    cyc();
    check("single_one_strobe", o_wb_rd_wvalid, 0);
    check("single_hold_addr", o_wb_rd_waddr, 5);
    check("single_log", wlog.size(), 1);

    // Simultaneous ALU and load to the same rd
    wlog.delete();
    i_alu_valid = 1'b1; i_alu_waddr = 5'd3; i_alu_wdata = 32'h11;
    i_ld_valid  = 1'b1; i_ld_waddr  = 5'd3; i_ld_wdata  = 32'h22;
    cyc();
    idle_inputs();
    check("sim_alu_ready_lo", o_alu_ready, 0);
    check("sim_ld_ready", o_ld_ready, 1);
    cyc();
    check("sim_first", {o_wb_rd_wvalid, o_wb_rd_waddr, o_wb_rd_wdata}, {1'b1, 5'd3, 32'h22});
    check("sim_alu_ready_hi", o_alu_ready, 1);
    cyc();
    check("sim_second", {o_wb_rd_wvalid, o_wb_rd_waddr, o_wb_rd_wdata}, {1'b1, 5'd3, 32'h11});
    cyc();
    check("sim_done", o_wb_rd_wvalid, 0);
    check("sim_log", wlog.size(), 2);

    // Starvation guard: continuous loads, one ALU result
    wlog.delete();
    ld_rd = 1;
    alu_pend = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_alu_valid = alu_pend; i_alu_waddr = 5'd7; i_alu_wdata = 32'h77;
      i_ld_valid  = (ld_rd <= 7);
      i_ld_waddr  = 5'(ld_rd);
      i_ld_wdata  = 32'h100 + 32'(ld_rd);
      #1;
      a_acc = i_alu_valid && o_alu_ready;
      l_acc = i_ld_valid && o_ld_ready;
      cyc();
      if (a_acc) alu_pend = 1'b0;
      if (l_acc) ld_rd++;
    end
    idle_inputs();
    cyc(); cyc(); cyc();
    exp_seq[0] = {5'd1, 32'h101};
    exp_seq[1] = {5'd2, 32'h102};
    exp_seq[2] = {5'd3, 32'h103};
    exp_seq[3] = {5'd4, 32'h104};
    exp_seq[4] = {5'd7, 32'h77};
    exp_seq[5] = {5'd5, 32'h105};
    exp_seq[6] = {5'd6, 32'h106};
    exp_seq[7] = {5'd7, 32'h107};
    check("starve_count", wlog.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wlog.size()) check($sformatf("starve_seq%0d", i), wlog[i], exp_seq[i]);
      else check($sformatf("starve_seq%0d_missing", i), 0, exp_seq[i]);
    end

    // Flush of an ALU result waiting behind loads
    wlog.delete();
    i_alu_valid = 1'b1; i_alu_waddr = 5'd9;  i_alu_wdata = 32'h99;
    i_ld_valid  = 1'b1; i_ld_waddr  = 5'd10; i_ld_wdata  = 32'hAA;
    cyc();
    i_alu_valid = 1'b0;
    i_ld_waddr = 5'd11; i_ld_wdata = 32'hBB;
    cyc();
    i_ld_waddr = 5'd12; i_ld_wdata = 32'hCC;
    cyc();
    i_ld_valid = 1'b0;
    check("flush_starve_pre", dut.starve_q, 2);
    i_flush = 1'b1;
    i_alu_valid = 1'b1; i_alu_waddr = 5'd9; i_alu_wdata = 32'h99;
    #1;
    check("flush_alu_ready", o_alu_ready, 0);
    cyc();
    idle_inputs();
    check("flush_starve_post", dut.starve_q, 0);
    cyc(); cyc(); cyc();
    check("flush_busy", o_busy, 0);
    check("flush_log", wlog.size(), 3);
    n9 = 0;
    foreach (wlog[i]) if (wlog[i][36:32] == 5'd9) n9++;
    check("flush_no_rd9", n9, 0);
    if (wlog.size() > 2) check("flush_last_ld", wlog[2], {5'd12, 32'hCC});

    // Load to x0 is consumed
    wlog.delete();
    i_ld_valid = 1'b1; i_ld_waddr = 5'd0; i_ld_wdata = 32'hFFFF_FFFF;
    #1;
    check("x0_ready", o_ld_ready, 1);
    cyc();
    idle_inputs();
    check("x0_busy", o_busy, 0);
    cyc(); cyc();
    check("x0_log", wlog.size(), 0);

    // Reset mid-operation drops the pending result
    wlog.delete();
    i_alu_valid = 1'b1; i_alu_waddr = 5'd6; i_alu_wdata = 32'h66;
    cyc();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mrst_busy", o_busy, 0);
    check("mrst_wvalid", o_wb_rd_wvalid, 0);
    cyc();
    check("mrst_wvalid2", o_wb_rd_wvalid, 0);
    check("mrst_log", wlog.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
